// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Owns the single-port frame-buffer RAM behind the VGA timing generator and
// decides, at every clock edge, who gets the RAM for the next cycle:
//   1. display scan-out (disp_ena=1) always gets a read slot;
//   2. a whole-frame clear writes CLEAR_VAL, one pixel per free slot;
//   3. buffered host pixel writes retire from a small FIFO;
//   4. otherwise the RAM is left idle.
// Host writes are only ever retired in blanking slots, so the display never
// loses a fetch.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   disp_ena, col, row            active-video flag and pixel position
//   host_valid/host_ready         host write handshake (accepted at posedge)
//   host_addr, host_data          linear pixel address and value
//   clear_req                     single-cycle frame clear request
//   clear_busy                    clear accepted and not yet finished
//   clear_done                    one-cycle pulse after the last clear write
//   host_err                      sticky: an out-of-range host write was dropped
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata          registered RAM port; rdata one cycle later
//   pix_valid, pix_data           fetched pixel to the DAC (0 when not valid)
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int H_PIXELS   = 50,
    parameter int V_PIXELS   = 25,
    parameter int H_BITS     = 7,
    parameter int V_BITS     = 5,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [H_BITS-1:0] col,
    input  logic [V_BITS-1:0] row,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              host_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data
);

    localparam int unsigned        TOTAL     = H_PIXELS * V_PIXELS;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;

    // Host write FIFO
    logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               fifo_empty, fifo_full;
    logic               ready_int;
    logic               accept, addr_in_range, push, pop;

    // Slot decision for the next RAM cycle
    logic               slot_en, slot_we;
    logic [ADDR_W-1:0]  slot_addr;
    logic [DATA_W-1:0]  slot_wdata;
    logic               done_d;
    logic [ADDR_W-1:0]  disp_addr;

    // Read-return tracking: high while mem_rdata carries a display fetch
    logic               rd_q;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    // Internal ready stays free of rst so the reset net only feeds async
    // resets; the port copy is forced low while reset is held.
    assign ready_int  = !fifo_full && (state_q == ST_IDLE);
    assign host_ready = ready_int && !rst;
    assign clear_busy = (state_q != ST_IDLE);

    assign accept        = host_valid && ready_int;
    assign addr_in_range = (32'(host_addr) < TOTAL);
    assign push          = accept && addr_in_range;

    // Linear scan-out address; wraps to ADDR_W bits for off-screen positions.
    assign disp_addr = ADDR_W'(32'(row) * 32'(H_PIXELS) + 32'(col));

    // -----------------------------------------------------------------------
    // Slot arbitration and clear FSM next-state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        slot_en    = 1'b0;
        slot_we    = 1'b0;
        slot_addr  = mem_addr;
        slot_wdata = mem_wdata;
        pop        = 1'b0;
        done_d     = 1'b0;

        if (disp_ena) begin
            slot_en   = 1'b1;
            slot_addr = disp_addr;
        end else if (state_q == ST_CLEAR) begin
            slot_en    = 1'b1;
            slot_we    = 1'b1;
            slot_addr  = clr_addr_q;
            slot_wdata = CLEAR_VAL;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (!fifo_empty) begin
            slot_en    = 1'b1;
            slot_we    = 1'b1;
            slot_addr  = fifo_addr[rd_ptr];
            slot_wdata = fifo_data[rd_ptr];
            pop        = 1'b1;
        end

        // The clear only starts once every earlier host write has retired,
        // so the frame ends up uniformly CLEAR_VAL.
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Registered RAM port and status outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            clear_done <= 1'b0;
            host_err   <= 1'b0;
        end else begin
            mem_en     <= slot_en;
            mem_we     <= slot_we;
            mem_addr   <= slot_addr;
            mem_wdata  <= slot_wdata;
            clear_done <= done_d;
            if (accept && !addr_in_range) begin
                host_err <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage carries no reset; entries are only read after the
    // reset-cleared pointers say they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_addr;
            fifo_data[wr_ptr] <= host_data;
        end
    end

    // -----------------------------------------------------------------------
    // Read return path: mem_rdata is valid the cycle after a registered read,
    // so the pixel lands two edges after disp_ena was sampled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q      <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_q      <= mem_en && !mem_we;
            pix_valid <= rd_q;
            pix_data  <= rd_q ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int H     = 50;
    localparam int V     = 25;
    localparam int TOTAL = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_ena;
    logic [6:0]  col;
    logic [4:0]  row;
    logic        host_valid;
    logic        host_ready;
    logic [10:0] host_addr;
    logic [7:0]  host_data;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;
    logic        host_err;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        pix_valid;
    logic [7:0]  pix_data;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .disp_ena   (disp_ena),
        .col        (col),
        .row        (row),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .host_err   (host_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data)
    );

    // Synchronous single-port RAM with a preload port used only during reset.
    logic [7:0]  ram [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model: expected frame contents, pending host writes in order,
    // the sticky error flag and the expected pixel two fetches back.
    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic [7:0] ref_fb [0:TOTAL-1];
    wr_t        q[$];
    bit         err_exp;
    bit         h1_v, h2_v;
    logic [7:0] h1_d, h2_d;
    int         pix_skip;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of normal (non-clear) operation, predicted from the rules:
    // display reads win, otherwise the oldest pending host write retires.
    task automatic cycle(input bit de, input int r, input int c,
                         input bit hv, input int ha, input int hd);
        bit         exp_ready, exp_en, exp_we, nv;
        int         exp_addr, exp_data;
        logic [7:0] nd;
        wr_t        w;
        disp_ena   = de;
        row        = 5'(r);
        col        = 7'(c);
        host_valid = hv;
        host_addr  = 11'(ha);
        host_data  = 8'(hd);
        exp_ready  = (q.size() < 4);
        #1;
        check("host_ready", host_ready, exp_ready);
        exp_en = 0; exp_we = 0; exp_addr = 0; exp_data = 0; nv = 0; nd = '0;
        if (de) begin
            exp_en   = 1;
            exp_addr = r * H + c;
            nv       = 1;
            nd       = ref_fb[exp_addr];
        end else if (q.size() > 0) begin
            w        = q.pop_front();
            exp_en   = 1;
            exp_we   = 1;
            exp_addr = w.addr;
            exp_data = w.data;
            ref_fb[w.addr] = 8'(w.data);
        end
        if (hv && exp_ready) begin
            if (ha < TOTAL) begin
                w.addr = ha;
                w.data = hd;
                q.push_back(w);
            end else begin
                err_exp = 1;
            end
        end
        @(posedge clk);
        #1;
        check("mem_en", mem_en, exp_en);
        check("mem_we", mem_we, exp_we);
        if (exp_en) check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, exp_data);
        check("host_err", host_err, err_exp);
        check("clear_busy_idle", clear_busy, 0);
        check("clear_done_idle", clear_done, 0);
        if (pix_skip > 0) begin
            pix_skip--;
        end else begin
            check("pix_valid", pix_valid, h2_v);
            check("pix_data", pix_data, h2_v ? h2_d : 8'h00);
        end
        h2_v = h1_v; h2_d = h1_d;
        h1_v = nv;   h1_d = nd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_t expw[$];
        wr_t log_q[$];
        int  a1, a2, d1, d2, old3, nz, bad_order, bad_ready, bad_busy, bad_slot;
        bit  done_seen;

        rst = 1'b1; disp_ena = 0; col = '0; row = '0;
        host_valid = 0; host_addr = '0; host_data = '0; clear_req = 0;
        err_exp = 0; h1_v = 0; h2_v = 0; h1_d = '0; h2_d = '0; pix_skip = 0;
        for (int i = 0; i < TOTAL; i++) ref_fb[i] = 8'($urandom);
        ref_fb[57] = 8'hA5;

        #2;
        check("rst_host_ready", host_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_clear_busy", clear_busy, 0);

        // Preload RAM while the arbiter is held in reset.
        for (int i = 0; i < TOTAL; i++) begin
            pre_we = 1'b1; pre_addr = 11'(i); pre_data = ref_fb[i];
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        rst    = 1'b0;

        cycle(0, 0, 0, 0, 0, 0);

        // Display read latency: row 1, col 7 -> address 57.
        cycle(1, 1, 7, 0, 0, 0);
        check("lat_addr", mem_addr, 57);
        check("lat_we", mem_we, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("lat_pv_early", pix_valid, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("lat_pv", pix_valid, 1);
        check("lat_pd", pix_data, 8'hA5);

        // Random scan-out with no host traffic.
        for (int i = 0; i < 40; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, V - 1), $urandom_range(0, H - 1), 0, 0, 0);

        // Write deferral during active video.
        old3 = ref_fb[3];
        cycle(1, 2, 5, 1, 3, 'h11);
        cycle(1, 3, 9, 0, 0, 0);
        check("defer_ram_untouched", ram[3], old3);
        cycle(1, 4, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("defer_we", mem_we, 1);
        check("defer_addr", mem_addr, 3);
        check("defer_data", mem_wdata, 'h11);
        cycle(0, 0, 0, 0, 0, 0);
        check("defer_ram_written", ram[3], 'h11);

        // FIFO full: five back-to-back attempts in active video.
        for (int i = 0; i < 5; i++)
            cycle(1, $urandom_range(0, V - 1), $urandom_range(0, H - 1),
                  1, $urandom_range(0, TOTAL - 1), $urandom_range(0, 255));
        check("full_ready_low", host_ready, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("ready_after_pop", host_ready, 1);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 4) < 3, $urandom_range(0, V - 1), $urandom_range(0, H - 1),
                  $urandom_range(0, 1), $urandom_range(0, TOTAL - 1), $urandom_range(0, 255));

        // Out-of-range host write.
        cycle(0, 0, 0, 1, TOTAL, 'h5A);
        check("oor_err", host_err, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
        check("oor_err_sticky", host_err, 1);

        // Clear with two writes queued.
        a1 = $urandom_range(0, TOTAL - 1); d1 = $urandom_range(1, 255);
        a2 = $urandom_range(0, TOTAL - 1); d2 = $urandom_range(1, 255);
        cycle(1, 0, 1, 1, a1, d1);
        cycle(1, 0, 2, 1, a2, d2);
        expw = q;
        disp_ena = 1; row = 5'd3; col = 7'd3; host_valid = 0; clear_req = 1;
        #1;
        check("clr_req_ready", host_ready, 1);
        @(posedge clk); #1;
        clear_req = 0;
        check("clr_busy_start", clear_busy, 1);
        check("clr_ready_low", host_ready, 0);

        done_seen = 0; bad_ready = 0; bad_busy = 0; bad_slot = 0;
        for (int n = 0; n < 20000 && !done_seen; n++) begin
            int  r, c;
            bit  de;
            wr_t w;
            de = $urandom_range(0, 1);
            r  = $urandom_range(0, V - 1);
            c  = $urandom_range(0, H - 1);
            disp_ena   = de; row = 5'(r); col = 7'(c);
            host_valid = $urandom_range(0, 1);
            host_addr  = 11'($urandom_range(0, TOTAL - 1));
            host_data  = 8'($urandom);
            clear_req  = ($urandom_range(0, 49) == 0);
            #1;
            if (host_ready) bad_ready++;
            @(posedge clk); #1;
            if (de) begin
                if (!(mem_en && !mem_we && mem_addr == 11'(r * H + c))) bad_slot++;
            end else if (mem_en && mem_we) begin
                w.addr = mem_addr;
                w.data = mem_wdata;
                log_q.push_back(w);
            end else if (mem_en) begin
                bad_slot++;
            end
            if (clear_done) done_seen = 1;
            else if (!clear_busy) bad_busy++;
        end
        clear_req = 0; host_valid = 0;
        check("clr_done_seen", done_seen, 1);
        check("clr_busy_at_done", clear_busy, 0);
        check("clr_ready_while_busy", bad_ready, 0);
        check("clr_busy_dropped", bad_busy, 0);
        check("clr_slot_priority", bad_slot, 0);
        check("clr_write_count", log_q.size(), 2 + TOTAL);
        bad_order = 0;
        if (log_q.size() == 2 + TOTAL) begin
            for (int i = 0; i < 2; i++)
                if (log_q[i].addr != expw[i].addr || log_q[i].data != expw[i].data) bad_order++;
            for (int i = 0; i < TOTAL; i++)
                if (log_q[2 + i].addr != i || log_q[2 + i].data != 0) bad_order++;
        end
        check("clr_write_order", bad_order, 0);

        q = {};
        for (int i = 0; i < TOTAL; i++) ref_fb[i] = 8'h00;
        pix_skip = 2;
        cycle(0, 0, 0, 0, 0, 0);
        check("clr_done_pulse_end", clear_done, 0);
        nz = 0;
        for (int i = 0; i < TOTAL; i++) if (ram[i] !== 8'h00) nz++;
        check("clr_ram_zero", nz, 0);
        for (int i = 0; i < 20; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, V - 1), $urandom_range(0, H - 1),
                  $urandom_range(0, 1), $urandom_range(0, TOTAL - 1), $urandom_range(0, 255));
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);

        // Reset asserted asynchronously in the middle of a clear.
        disp_ena = 0; host_valid = 0; clear_req = 1;
        @(posedge clk); #1;
        clear_req = 0;
        repeat (20) @(posedge clk);
        #3;
        check("pre_rst_busy", clear_busy, 1);
        check("pre_rst_we", mem_we, 1);
        rst = 1'b1;
        #1;
        check("arst_host_ready", host_ready, 0);
        check("arst_clear_busy", clear_busy, 0);
        check("arst_clear_done", clear_done, 0);
        check("arst_host_err", host_err, 0);
        check("arst_mem_en", mem_en, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_pix_valid", pix_valid, 0);
        check("arst_pix_data", pix_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q = {}; err_exp = 0; h1_v = 0; h2_v = 0; pix_skip = 0;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 10, 'h77);
        cycle(0, 0, 0, 0, 0, 0);
        check("post_rst_write_addr", mem_addr, 10);
        cycle(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single-port frame-buffer RAM that feeds the VGA timing generator.
- Arbitrates RAM access between two sources:
  - display scan-out, which always wins when disp_ena=1;
  - host pixel writes, buffered in a small FIFO and retired only in blanking cycles.
- Also provides a whole-frame clear sequencer.
- Sits between the timing generator (disp_ena/col/row) and the RAM; the pixel output goes to the DAC.

Parameters:
- H_PIXELS, 50, visible columns per line
- V_PIXELS, 25, visible lines per frame
- H_BITS, 7, width of col
- V_BITS, 5, width of row
- ADDR_W, 11, RAM address width; must satisfy H_PIXELS*V_PIXELS <= 2^ADDR_W
- DATA_W, 8, pixel width
- FIFO_DEPTH, 4, host write FIFO entries (power of two)
- CLEAR_VAL, 0, pixel value written by a clear

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- disp_ena  in  1  active-video flag from timing generator
- col  in  H_BITS  current column
- row  in  V_BITS  current row
- host_valid  in  1  host write request
- host_ready  out  1  host write accepted when host_valid & host_ready at posedge
- host_addr  in  ADDR_W  linear pixel address
- host_data  in  DATA_W  pixel value
- clear_req  in  1  single-cycle request to clear the frame
- clear_busy  out  1  high from clear_req acceptance until clear completes
- clear_done  out  1  one-cycle pulse after the last clear write
- host_err  out  1  sticky: out-of-range host address was dropped
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en & !mem_we
- pix_valid  out  1  pix_data is a fetched pixel
- pix_data  out  DATA_W  pixel to DAC, 0 when pix_valid=0

Behaviour:
- Reset (async, immediate):
  - all outputs 0;
  - FIFO empty, state IDLE, clear counter 0, read pipeline flushed.
  - An assertion mid-clear or mid-write abandons the operation; no partial resume.
- All mem_* outputs are registered.
- Slot decision is made at every posedge from the sampled inputs, in this priority order:
  1. disp_ena=1: read slot. mem_en=1, mem_we=0, mem_addr = row*H_PIXELS + col, truncated to ADDR_W.
  2. state CLEAR: write CLEAR_VAL at clr_addr, then clr_addr+1.
  3. FIFO non-empty (IDLE or DRAIN): pop the head, mem_en=1, mem_we=1, address/data from the entry.
  4. Otherwise: mem_en=0, mem_we=0.
- Read latency:
  - disp_ena sampled at edge k → mem_en at edge k → RAM data at edge k+1 → pix_data/pix_valid registered at edge k+2.
  - pix_valid is therefore disp_ena delayed by 2 cycles; pix_data is forced to 0 when it would be invalid.
- Host FIFO:
  - host_ready = !full & (state==IDLE); combinational from registered state.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Addresses >= H_PIXELS*V_PIXELS are accepted (handshake completes) but not enqueued, and set host_err. Only rst clears host_err.
  - FIFO order is preserved; no write reordering.
- Clear state machine (IDLE, DRAIN, CLEAR):
  - IDLE: clear_req=1 → DRAIN, clear_busy=1. clear_req in any other state is ignored.
  - DRAIN: host_ready=0; FIFO retires in blanking slots. When the FIFO is empty → CLEAR, clr_addr=0.
  - CLEAR: one write per non-display cycle. The write at clr_addr = H_PIXELS*V_PIXELS-1 → IDLE next edge; clear_busy=0 and clear_done=1 for exactly that cycle.
  - Display reads continue throughout and always preempt clear writes.
- No starvation analysis is needed: the timing generator guarantees horizontal blanking on every line.

Test Plan:
- Reset mid-clear: rst asserted mid-clear, asynchronously → all outputs 0 without a clock edge. After release: host_ready=1, clear_busy=0, FIFO empty.
- Display read latency: preload RAM addr 57 = 0xA5; drive disp_ena=1, row=1, col=7 → mem_addr=57 and mem_we=0 at the next edge; pix_valid=1 and pix_data=0xA5 two edges after sampling.
- Write deferral: host writes addr 3 = 0x11 during active video → accepted into the FIFO, RAM untouched. First blanking cycle → mem_we=1, mem_addr=3, mem_wdata=0x11.
- FIFO full: 5 back-to-back writes while disp_ena=1 → host_ready drops after 4 are accepted. On the first blanking cycle, one pop occurs and host_ready reasserts.
- Out-of-range write: host_addr=1250 → handshake completes, no RAM write, host_err=1 and it stays high.
- Clear: clear_req with 2 writes queued → the 2 writes retire first, then 1250 clear writes (addresses 0..1249 = 0) interleaved with display reads. Then clear_done pulses for 1 cycle and host_ready returns to 1.
